// File: rtl/simple_out_capture.sv
// Capture stage for the simple block's out net: samples a programmable window
// and compacts it into a ones count, a transition count and a MISR signature.
module simple_out_capture #(
    parameter int                WIN_W = 16,
    parameter int                SIG_W = 16,
    parameter logic [SIG_W-1:0]  POLY  = 16'h1021,
    parameter logic [SIG_W-1:0]  SEED  = 16'h0000
) (
    input  logic             iccad_clk,
    input  logic             rst_n,
    input  logic             out_in,
    input  logic             start,
    input  logic [WIN_W-1:0] window_len,
    output logic             busy,
    output logic             done,
    output logic [WIN_W-1:0] ones_cnt,
    output logic [WIN_W-1:0] edge_cnt,
    output logic [SIG_W-1:0] sig
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_out_q;
    logic             r_prev;
    logic             r_first;
    logic [WIN_W-1:0] r_remain;
    logic [WIN_W-1:0] r_ones_cnt;
    logic [WIN_W-1:0] r_edge_cnt;
    logic [SIG_W-1:0] r_sig;

    logic             w_accept;
    logic             w_capture;
    logic             w_last;
    logic             w_edge;
    logic [WIN_W-1:0] w_ones_nxt;
    logic [WIN_W-1:0] w_edge_nxt;
    logic [SIG_W-1:0] w_sig_nxt;

    assign w_accept  = (r_state == S_IDLE) && start;
    assign w_capture = (r_state == S_CAPTURE);
    assign w_last    = (r_remain <= WIN_W'(1));
    assign w_edge    = !r_first && (r_out_q != r_prev);

    // Counters stick at all-ones rather than wrapping
    assign w_ones_nxt = (r_out_q && (r_ones_cnt != '1))
                      ? r_ones_cnt + WIN_W'(1) : r_ones_cnt;
    assign w_edge_nxt = (w_edge && (r_edge_cnt != '1))
                      ? r_edge_cnt + WIN_W'(1) : r_edge_cnt;

    assign w_sig_nxt = {r_sig[SIG_W-2:0], 1'b0}
                     ^ (r_sig[SIG_W-1] ? POLY : '0)
                     ^ SIG_W'(r_out_q);

    always_ff @(posedge iccad_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = (window_len != '0) ? S_CAPTURE : S_DONE;
                end
            end
            S_CAPTURE: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge iccad_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_q    <= 1'b0;
            r_prev     <= 1'b0;
            r_first    <= 1'b1;
            r_remain   <= '0;
            r_ones_cnt <= '0;
            r_edge_cnt <= '0;
            r_sig      <= SEED;
        end else begin
            r_out_q <= out_in;
            if (w_accept) begin
                r_remain   <= window_len;
                r_ones_cnt <= '0;
                r_edge_cnt <= '0;
                r_sig      <= SEED;
                r_first    <= 1'b1;
            end else if (w_capture) begin
                r_ones_cnt <= w_ones_nxt;
                r_edge_cnt <= w_edge_nxt;
                r_sig      <= w_sig_nxt;
                r_prev     <= r_out_q;
                r_first    <= 1'b0;
                r_remain   <= (r_remain != '0) ? r_remain - WIN_W'(1) : '0;
            end
        end
    end

    // Status comes straight from the state register, never from inputs
    assign busy     = (r_state == S_CAPTURE);
    assign done     = (r_state == S_DONE);
    assign ones_cnt = r_ones_cnt;
    assign edge_cnt = r_edge_cnt;
    assign sig      = r_sig;

endmodule

// File: doc/simple_out_capture.md
# simple_out_capture

Capture and compaction stage that sits directly downstream of the `simple` netlist block and consumes its single-bit `out` output. On a `start` request it samples `out` for a programmable number of `iccad_clk` cycles. Over that window it accumulates three results: a count of 1-samples, a count of transitions, and a multiple-input signature register (MISR) signature. It then reports completion with a one-cycle `done` pulse. Results are held stable for readback by the test/compare logic.

## Interface
- `WIN_W`, 16: width of `window_len`, `ones_cnt` and `edge_cnt`.
- `SIG_W`, 16: MISR width.
- `POLY`, 16'h1021: MISR feedback polynomial (taps XORed in when the MSB is shifted out).
- `SEED`, 16'h0000: MISR value loaded at each `start`.

Ports:
- `iccad_clk`, in, 1: sole clock; all state updates on its rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `out_in`, in, 1: the `simple` block's `out` net.
- `start`, in, 1: capture request; honoured only in IDLE.
- `window_len`, in, WIN_W: number of samples; latched at accepted `start`.
- `busy`, out, 1: high while capturing.
- `done`, out, 1: one-cycle completion pulse.
- `ones_cnt`, out, WIN_W: number of samples equal to 1.
- `edge_cnt`, out, WIN_W: number of sample-to-sample value changes.
- `sig`, out, SIG_W: MISR signature.

## Operation
- **Input register.**
  - `out_q` registers `out_in` every cycle, regardless of state.
  - All capture logic consumes `out_q`, never `out_in` directly, because `out` is combinational from the upstream flop.
- **State machine:** IDLE, CAPTURE, DONE.
  - IDLE + `start` + `window_len` != 0: latch `window_len` into `remain`; clear `ones_cnt` and `edge_cnt`; load `sig` = SEED; clear `first` flag to 1; go to CAPTURE.
  - IDLE + `start` + `window_len` == 0: clear counters, load `sig` = SEED, go directly to DONE. No samples are taken.
  - CAPTURE, each cycle, consume one sample `b` = `out_q`:
    - `ones_cnt` += `b`.
    - If `first` == 0 and `b` != `prev`: `edge_cnt` += 1.
    - `prev` = `b`; `first` = 0.
    - `sig` = {`sig`[SIG_W-2:0], 0} ^ (`sig`[SIG_W-1] ? POLY : 0) ^ {0…0, `b`}.
    - `remain` -= 1; when `remain` == 1 on this cycle, go to DONE.
  - DONE: `done` = 1 for exactly this cycle; next state IDLE unconditionally.
- **Saturation.** Counters saturate at all-ones and never wrap. `remain` cannot underflow.
- **Ignored `start`.** `start` in CAPTURE or DONE is ignored: not queued, no effect.
- **`window_len` changes.** Changes to `window_len` outside an accepted `start` have no effect.
- **Result hold.** `ones_cnt`, `edge_cnt` and `sig` hold their final values from DONE until the next accepted `start`.

## Timing
- **Reset values** (asynchronous, while `rst_n` = 0):
  - State = IDLE.
  - `busy` = 0, `done` = 0, `ones_cnt` = 0, `edge_cnt` = 0.
  - `sig` = SEED, `out_q` = 0, `prev` = 0, `first` = 1, `remain` = 0.
- **Start edge.** `start` is sampled at edge T, in IDLE. `busy` = 1 from T+1 through the last capture cycle.
- **Samples.** Samples are the `out_q` values present during cycles T+1 … T+N. Sample k equals `out_in` at edge T+k-1, so the first sample is `out_in` at the start edge.
- **Completion.** `done` is high in cycle T+N+1 and `busy` is 0 in that same cycle. The earliest next `start` is accepted at edge T+N+2. Start-to-done latency is N+1 cycles.
- **Zero-length window.** With N = 0, `done` is high in cycle T+1 and `busy` never rises.
- **Output registers.** `busy` and `done` are registered outputs; there is no combinational path from inputs to outputs.
- **Reset mid-operation.** Reset during CAPTURE or DONE aborts immediately to reset values. No `done` pulse is issued for the aborted window.

## Test plan
- **Reset during capture.** Assert `rst_n` = 0 mid-capture → all outputs read reset values within the same cycle, independent of the clock; after release, `start` behaves normally.
- **All zeros, N = 8.** `out_in` held 0, `window_len` = 8 → `busy` high 8 cycles, `done` pulse 9 cycles after `start`, `ones_cnt` = 0, `edge_cnt` = 0, `sig` = 0x0000.
- **All ones, N = 3.** `out_in` held 1, `window_len` = 3 → `ones_cnt` = 3, `edge_cnt` = 0, `sig` = 0x0007.
- **Alternating, N = 6.** `out_in` alternating 1,0,1,0,1,0 starting at the start edge → `ones_cnt` = 3, `edge_cnt` = 5.
- **Zero-length window.** `window_len` = 0 → `done` in the cycle after `start`, `busy` stays 0, counters 0, `sig` = SEED.
- **Ignored `start`.** Pulse `start` during CAPTURE and during DONE → ignored; only one `done` pulse, and results match the single original window.
